capture_ctrl: RTL and testbench

CAPTURE_CTRL -- requirements
Module: capture_ctrl

---
 rtl/oscope_pkg.sv | 16 +
 rtl/trig_detect.sv | 17 +
 rtl/capture_ctrl.sv | 132 +++++++++++++
 tb/tb_capture_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/oscope_pkg.sv
// Shared types and widths for the oscilloscope capture path.
package oscope_pkg;

    localparam int DATA_W        = 8;
    localparam int ADDR_W        = 15;
    localparam int DEPTH_DEFAULT = 25000;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_TRIG,
        CAPTURE,
        READY
    } state_t;

endpackage

// File: rtl/trig_detect.sv
// Level-crossing detector: hit when the sample pair crosses level in the selected direction.
module trig_detect
    import oscope_pkg::*;
(
    input  logic [DATA_W-1:0] prev,
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] level,
    input  logic              rising,
    output logic              hit
);

    always_comb begin
        if (rising) hit = (prev < level) && (cur >= level);
        else        hit = (prev > level) && (cur <= level);
    end

endmodule

// File: rtl/capture_ctrl.sv
// Triggered capture controller: arms, waits for a level crossing, writes DEPTH samples, hands off to the Pi.
// Optional forced trigger after a timeout when CAPTURE_CTRL_AUTO_TRIG_EN is defined.
module capture_ctrl
    import oscope_pkg::*;
#(
    parameter int DEPTH        = DEPTH_DEFAULT,
    parameter int AUTO_TIMEOUT = 65535
) (
    input  logic              osc_clk,
    input  logic              reset,
    input  logic              run,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic              trig_rising,
    input  logic              pi_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              pi_signal_flag,
    output logic              auto_trig
);

    if (DEPTH < 1 || DEPTH > (1 << ADDR_W) || AUTO_TIMEOUT < 1) begin : g_param_check
        $error("capture_ctrl: DEPTH or AUTO_TIMEOUT out of range");
    end

    state_t            state, next_state;
    logic [ADDR_W-1:0] wr_cnt;
    logic [DATA_W-1:0] prev_sample;
    logic [2:0]        pi_sync;
    logic              pi_edge;
    logic              hit;
    logic              forced;
    logic              trig_fire;
    logic              cap_wr;
    logic              last_wr;

    trig_detect u_trig_detect (
        .prev   (prev_sample),
        .cur    (sample_data),
        .level  (trig_level),
        .rising (trig_rising),
        .hit    (hit)
    );

    // pi_sync[1:0] is the synchronizer; pi_sync[2] is the delayed copy for edge detection
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) pi_sync <= '0;
        else       pi_sync <= {pi_sync[1:0], pi_done};
    end
    assign pi_edge = pi_sync[1] & ~pi_sync[2];

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (run) next_state = ARM;
            ARM: begin
                if (!run)              next_state = IDLE;
                else if (sample_valid) next_state = WAIT_TRIG;
            end
            WAIT_TRIG: begin
                if (!run)           next_state = IDLE;
                else if (trig_fire) next_state = last_wr ? READY : CAPTURE;
            end
            CAPTURE:   if (last_wr) next_state = READY;
            READY:     if (pi_edge) next_state = run ? ARM : IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        pi_signal_flag = (state == READY);
        trig_fire      = (state == WAIT_TRIG) && run && sample_valid && (hit || forced);
        cap_wr         = (state == CAPTURE) && sample_valid;
        last_wr        = (trig_fire && DEPTH == 1) ||
                         (cap_wr && wr_cnt == ADDR_W'(DEPTH - 1));
    end

    // wr_cnt is the next write address; the final write moves to READY so it never wraps
    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_cnt      <= '0;
            prev_sample <= '0;
        end else begin
            wr_en <= trig_fire | cap_wr;
            if (trig_fire) begin
                wr_addr <= '0;
                wr_data <= sample_data;
                wr_cnt  <= ADDR_W'(1);
            end else if (cap_wr) begin
                wr_addr <= wr_cnt;
                wr_data <= sample_data;
                wr_cnt  <= wr_cnt + ADDR_W'(1);
            end
            if (sample_valid && (state == ARM || state == WAIT_TRIG))
                prev_sample <= sample_data;
        end
    end

`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
    localparam int TMO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TMO_W-1:0] tmo_cnt;

    assign forced = (tmo_cnt == TMO_W'(AUTO_TIMEOUT));

    always_ff @(posedge osc_clk or posedge reset) begin
        if (reset) begin
            tmo_cnt   <= '0;
            auto_trig <= 1'b0;
        end else begin
            if (state != WAIT_TRIG) tmo_cnt <= '0;
            else if (!forced)       tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (trig_fire)                                auto_trig <= forced & ~hit;
            else if (next_state == ARM && state != ARM)   auto_trig <= 1'b0;
        end
    end
`else
    assign forced    = 1'b0;
    assign auto_trig = 1'b0;
`endif

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed self-checking bench for capture_ctrl with DEPTH=16 and AUTO_TIMEOUT=100.
module tb_capture_ctrl;

    logic        osc_clk = 1'b0;
    logic        reset;
    logic        run;
    logic        sample_valid;
    logic [7:0]  sample_data;
    logic [7:0]  trig_level;
    logic        trig_rising;
    logic        pi_done;
    logic        wr_en;
    logic [14:0] wr_addr;
    logic [7:0]  wr_data;
    logic        pi_signal_flag;
    logic        auto_trig;

    int errors = 0;
    int checks = 0;

    capture_ctrl #(.DEPTH(16), .AUTO_TIMEOUT(100)) dut (
        .osc_clk        (osc_clk),
        .reset          (reset),
        .run            (run),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .trig_level     (trig_level),
        .trig_rising    (trig_rising),
        .pi_done        (pi_done),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .pi_signal_flag (pi_signal_flag),
        .auto_trig      (auto_trig)
    );

    always #5 osc_clk = ~osc_clk;

    // Present one sample across a single rising edge; returns on the following falling edge.
    task automatic send(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(negedge osc_clk);
        sample_valid = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL %s wr_en: got %b want 0", tag, wr_en); end
        checks++; if (wr_addr !== 15'd0) begin errors++; $display("FAIL %s wr_addr: got %0d want 0", tag, wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL %s wr_data: got %h want 00", tag, wr_data); end
        checks++; if (pi_signal_flag !== 1'b0) begin errors++; $display("FAIL %s pi_signal_flag: got %b want 0", tag, pi_signal_flag); end
        checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL %s auto_trig: got %b want 0", tag, auto_trig); end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge osc_clk);
        check_all_zero("reset");
        reset = 1'b0;
        @(negedge osc_clk);
    endtask

    task automatic test_rising_trigger;
        trig_level  = 8'h80;
        trig_rising = 1'b1;
        run         = 1'b1;
        @(negedge osc_clk);
        send(8'h70);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rise_arm wr_en: got %b want 0", wr_en); end
        send(8'h90);
        checks++; if (wr_en !== 1'b1) begin errors++; $display("FAIL rise_trig wr_en: got %b want 1", wr_en); end
        checks++; if (wr_addr !== 15'd0) begin errors++; $display("FAIL rise_trig wr_addr: got %0d want 0", wr_addr); end
        checks++; if (wr_data !== 8'h90) begin errors++; $display("FAIL rise_trig wr_data: got %h want 90", wr_data); end
        checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL rise_trig auto_trig: got %b want 0", auto_trig); end
        @(negedge osc_clk);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL rise_pulse wr_en: got %b want 0", wr_en); end
    endtask

    // Continues the capture started by the rising trigger; pi_done toggles mid-capture and must be ignored.
    task automatic test_full_capture;
        logic [7:0] d;
        for (int k = 1; k < 16; k++) begin
            if (k == 5) pi_done = 1'b1;
            if (k == 8) pi_done = 1'b0;
            d = 8'(8'h20 + k);
            send(d);
            checks++; if (wr_en !== 1'b1 || wr_addr !== 15'(k) || wr_data !== d) begin
                errors++;
                $display("FAIL cap_write%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                         k, wr_en, wr_addr, wr_data, k, d);
            end
            if (k < 15) begin
                checks++; if (pi_signal_flag !== 1'b0) begin errors++; $display("FAIL cap_flag%0d: got %b want 0", k, pi_signal_flag); end
                @(negedge osc_clk);
            end
        end
        checks++; if (pi_signal_flag !== 1'b1) begin errors++; $display("FAIL ready_flag: got %b want 1", pi_signal_flag); end
        repeat (5) @(negedge osc_clk);
        checks++; if (pi_signal_flag !== 1'b1) begin errors++; $display("FAIL ready_hold: got %b want 1", pi_signal_flag); end
        send(8'h55);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL extra_sample wr_en: got %b want 0", wr_en); end
        checks++; if (wr_addr !== 15'd15) begin errors++; $display("FAIL extra_sample wr_addr: got %0d want 15", wr_addr); end
    endtask

    task automatic test_pi_done;
        int n;
        n = 0;
        pi_done = 1'b1;
        while (pi_signal_flag === 1'b1 && n < 6) begin
            @(negedge osc_clk);
            n++;
        end
        checks++; if (pi_signal_flag !== 1'b0 || n > 3) begin
            errors++;
            $display("FAIL pi_done_release: flag=%b after %0d cycles want 0 within 3", pi_signal_flag, n);
        end
        pi_done = 1'b0;
        @(negedge osc_clk);
    endtask

    // Starts in ARM (run held high through the pi_done release).
    task automatic test_falling_trigger;
        trig_rising = 1'b0;
        send(8'h90);
        send(8'h81);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL fall_81 wr_en: got %b want 0", wr_en); end
        send(8'h90);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL fall_90 wr_en: got %b want 0", wr_en); end
        send(8'h80);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 15'd0 || wr_data !== 8'h80) begin
            errors++;
            $display("FAIL fall_trig: got en=%b addr=%0d data=%h want en=1 addr=0 data=80", wr_en, wr_addr, wr_data);
        end
    endtask

    task automatic test_reset_mid_capture;
        logic [7:0] d;
        for (int k = 1; k <= 6; k++) begin
            d = 8'(8'h40 + k);
            send(d);
            checks++; if (wr_en !== 1'b1 || wr_addr !== 15'(k) || wr_data !== d) begin
                errors++;
                $display("FAIL mid_write%0d: got en=%b addr=%0d data=%h want en=1 addr=%0d data=%h",
                         k, wr_en, wr_addr, wr_data, k, d);
            end
        end
        reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge osc_clk);
        reset = 1'b0;
        @(negedge osc_clk);
    endtask

    // Dropping run in WAIT_TRIG must return to IDLE, so the next sample is only latched in ARM.
    task automatic test_run_abort_restart;
        trig_rising = 1'b1;
        trig_level  = 8'h80;
        run         = 1'b1;
        @(negedge osc_clk);
        send(8'h70);
        run = 1'b0;
        repeat (2) @(negedge osc_clk);
        run = 1'b1;
        repeat (2) @(negedge osc_clk);
        send(8'h90);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL abort_rearm wr_en: got %b want 0", wr_en); end
        send(8'h70);
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL abort_below wr_en: got %b want 0", wr_en); end
        send(8'h90);
        checks++; if (wr_en !== 1'b1 || wr_addr !== 15'd0 || wr_data !== 8'h90) begin
            errors++;
            $display("FAIL restart_trig: got en=%b addr=%0d data=%h want en=1 addr=0 data=90", wr_en, wr_addr, wr_data);
        end
        checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL restart auto_trig: got %b want 0", auto_trig); end
    endtask

    // Constant 0x10 never crosses 0x80; samples every 10 cycles, forced trigger expected on the 11th.
    task automatic test_auto_trig;
        reset = 1'b1;
        @(negedge osc_clk);
        reset = 1'b0;
        run   = 1'b1;
        @(negedge osc_clk);
        send(8'h10);
        for (int k = 1; k <= 11; k++) begin
            repeat (9) @(negedge osc_clk);
            send(8'h10);
            if (k <= 10) begin
                checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL auto_early%0d wr_en: got %b want 0", k, wr_en); end
            end
        end
`ifdef CAPTURE_CTRL_AUTO_TRIG_EN
        checks++; if (wr_en !== 1'b1 || wr_addr !== 15'd0 || wr_data !== 8'h10) begin
            errors++;
            $display("FAIL auto_fire: got en=%b addr=%0d data=%h want en=1 addr=0 data=10", wr_en, wr_addr, wr_data);
        end
        checks++; if (auto_trig !== 1'b1) begin errors++; $display("FAIL auto_flag: got %b want 1", auto_trig); end
`else
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL no_auto wr_en: got %b want 0", wr_en); end
        checks++; if (auto_trig !== 1'b0) begin errors++; $display("FAIL no_auto auto_trig: got %b want 0", auto_trig); end
`endif
    endtask

    initial begin
        reset        = 1'b1;
        run          = 1'b0;
        sample_valid = 1'b0;
        sample_data  = 8'h00;
        trig_level   = 8'h80;
        trig_rising  = 1'b1;
        pi_done      = 1'b0;
        @(negedge osc_clk);
        test_reset;
        test_rising_trigger;
        test_full_capture;
        test_pi_done;
        test_falling_trigger;
        test_reset_mid_capture;
        test_run_abort_restart;
        test_auto_trig;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
